// File: rtl/czonotope_stream_tx_if.sv
// ============================================================================
// Module : CZonotope (interface)
// Brief  : Constrained zonotope storage bus (n, ng, nc, c, G, A, b).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface CZonotope #(
    parameter int NMAX       = 512,
    parameter int NGMAX      = 512,
    parameter int NCMAX      = 512,
    parameter int DATA_WIDTH = 32
);
    localparam int MAX_DIM = (NMAX > NGMAX) ? ((NMAX > NCMAX) ? NMAX : NCMAX)
                                            : ((NGMAX > NCMAX) ? NGMAX : NCMAX);
    // One spare bit so that oversize dimensions are representable and rejectable.
    localparam int DIM_W = $clog2(MAX_DIM + 1) + 1;

    logic [DIM_W-1:0]      n;
    logic [DIM_W-1:0]      ng;
    logic [DIM_W-1:0]      nc;
    logic [DATA_WIDTH-1:0] c [NMAX];
    logic [DATA_WIDTH-1:0] G [NMAX][NGMAX];
    logic [DATA_WIDTH-1:0] A [NCMAX][NGMAX];
    logic [DATA_WIDTH-1:0] b [NCMAX];

    modport src  (output n, ng, nc, c, G, A, b);
    modport sink (input  n, ng, nc, c, G, A, b);
endinterface

`default_nettype wire

// File: rtl/czonotope_stream_tx.sv
// ============================================================================
// Module : czonotope_stream_tx
// Brief  : Serializes a CZonotope as HDR, c, G, A, b words over valid/ready.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module czonotope_stream_tx #(
    parameter int NMAX       = 512,
    parameter int NGMAX      = 512,
    parameter int NCMAX      = 512,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    CZonotope.sink                Z,
    input  logic                  start_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [2:0]            sec_o,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int MAX_DIM = (NMAX > NGMAX) ? ((NMAX > NCMAX) ? NMAX : NCMAX)
                                            : ((NGMAX > NCMAX) ? NGMAX : NCMAX);
    localparam int DIM_W = $clog2(MAX_DIM + 1) + 1;
    localparam int NI_W  = $clog2(NMAX);
    localparam int GI_W  = $clog2(NGMAX);
    localparam int CI_W  = $clog2(NCMAX);
    localparam logic [DIM_W-1:0] NMAX_V  = DIM_W'(NMAX);
    localparam logic [DIM_W-1:0] NGMAX_V = DIM_W'(NGMAX);
    localparam logic [DIM_W-1:0] NCMAX_V = DIM_W'(NCMAX);

    // Encodings of the streaming states double as the sec_o tag.
    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_C    = 3'd1,
        S_G    = 3'd2,
        S_A    = 3'd3,
        S_B    = 3'd4,
        S_IDLE = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic [DIM_W-1:0]      row_q, row_d, col_q, col_d;
    logic [1:0]            hdr_q, hdr_d;
    logic [DIM_W-1:0]      n_q, n_d, ng_q, ng_d, nc_q, nc_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d, last_q, last_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [2:0]            sec_q, sec_d;

    logic                  w_hs, w_adv, w_last;
    logic [DATA_WIDTH-1:0] w_word;
    state_t                w_after_hdr, w_after_c, w_after_g, w_after_a;

    assign w_hs = valid_q & ready_i;

    // First non-empty section following each section (IDLE = end of transfer).
    assign w_after_a   = (nc_q != '0) ? S_B : S_IDLE;
    assign w_after_g   = ((nc_q != '0) && (ng_q != '0)) ? S_A : w_after_a;
    assign w_after_c   = ((n_q  != '0) && (ng_q != '0)) ? S_G : w_after_g;
    assign w_after_hdr = (n_q != '0) ? S_C : w_after_c;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        hdr_d   = hdr_q;
        n_d     = n_q;
        ng_d    = ng_q;
        nc_d    = nc_q;
        w_adv   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d  = Z.n;
                    ng_d = Z.ng;
                    nc_d = Z.nc;
                    if ((Z.n > NMAX_V) || (Z.ng > NGMAX_V) || (Z.nc > NCMAX_V)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_HDR;
                        hdr_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                        w_adv   = 1'b1;
                    end
                end
            end
            S_HDR: begin
                if (w_hs) begin
                    w_adv = 1'b1;
                    if (hdr_q == 2'd2) begin
                        hdr_d   = '0;
                        state_d = w_after_hdr;
                    end else begin
                        hdr_d = hdr_q + 1'b1;
                    end
                end
            end
            S_C: begin
                if (w_hs) begin
                    w_adv = 1'b1;
                    if (row_q == n_q - 1'b1) begin
                        row_d   = '0;
                        state_d = w_after_c;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            S_G, S_A: begin
                if (w_hs) begin
                    w_adv = 1'b1;
                    if (col_q == ng_q - 1'b1) begin
                        col_d = '0;
                        if (row_q == ((state_q == S_G) ? n_q : nc_q) - 1'b1) begin
                            row_d   = '0;
                            state_d = (state_q == S_G) ? w_after_g : w_after_a;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_B: begin
                if (w_hs) begin
                    w_adv = 1'b1;
                    if (row_q == nc_q - 1'b1) begin
                        row_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Word at the next position; the output register is loaded from it.
    always_comb begin
        w_word = '0;
        case (state_d)
            S_HDR: begin
                case (hdr_d)
                    2'd0:    w_word = DATA_WIDTH'(n_d);
                    2'd1:    w_word = DATA_WIDTH'(ng_d);
                    default: w_word = DATA_WIDTH'(nc_d);
                endcase
            end
            S_C:     w_word = Z.c[row_d[NI_W-1:0]];
            S_G:     w_word = Z.G[row_d[NI_W-1:0]][col_d[GI_W-1:0]];
            S_A:     w_word = Z.A[row_d[CI_W-1:0]][col_d[GI_W-1:0]];
            S_B:     w_word = Z.b[row_d[CI_W-1:0]];
            default: w_word = '0;
        endcase
    end

    // The final word sits in the last non-empty section: B, else G, else C, else HDR.
    assign w_last = ((state_d == S_HDR) && (hdr_d == 2'd2) && (n_d == '0) && (nc_d == '0))
                 || ((state_d == S_C) && (row_d == n_d - 1'b1) && (nc_d == '0) && (ng_d == '0))
                 || ((state_d == S_G) && (row_d == n_d - 1'b1) && (col_d == ng_d - 1'b1)
                     && (nc_d == '0))
                 || ((state_d == S_B) && (row_d == nc_d - 1'b1));

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        sec_d   = sec_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (w_adv) begin
            if (state_d == S_IDLE) begin
                data_d  = '0;
                valid_d = 1'b0;
                sec_d   = '0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                data_d  = w_word;
                valid_d = 1'b1;
                sec_d   = state_d;
                last_d  = w_last;
                busy_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            hdr_q   <= '0;
            n_q     <= '0;
            ng_q    <= '0;
            nc_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sec_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            hdr_q   <= hdr_d;
            n_q     <= n_d;
            ng_q    <= ng_d;
            nc_q    <= nc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sec_q   <= sec_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign sec_o   = sec_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule

`default_nettype wire

// File: doc/czonotope_stream_tx.md
# czonotope_stream_tx

Serializes a constrained zonotope held on a `CZonotope` interface into a word stream with a valid/ready handshake. It is the transmit end of the CZonotope word-stream link: it sends results such as a linear-image output off-block, to a host, a FIFO or a remote loader, in a fixed order. The stream is a header followed by the c, G, A and b sections. A single start pulse snapshots the dimensions and the block then walks every element with row/column counters.

## Interface
- `NMAX`, default 512: maximum state dimension n.
- `NGMAX`, default 512: maximum number of generators ng.
- `NCMAX`, default 512: maximum number of constraints nc.
- `DATA_WIDTH`, default 32: element and stream word width.
- `clk_i`  in  1: clock.
- `rstn_i`  in  1: asynchronous active-low reset.
- `Z`  interface  CZonotope: source set (n, ng, nc, c, G, A, b). Read-only here. The source holds it stable from `start_i` until `done_o`.
- `start_i`  in  1: one-cycle request to transmit Z.
- `data_o`  out  DATA_WIDTH: stream word.
- `valid_o`  out  1: `data_o` is valid.
- `ready_i`  in  1: sink accepts the word.
- `sec_o`  out  3: section tag of the current word. 0 = HDR, 1 = C, 2 = G, 3 = A, 4 = B.
- `last_o`  out  1: final word of the transfer.
- `busy_o`  out  1: transfer in progress.
- `done_o`  out  1: one-cycle pulse after the last handshake.
- `err_o`  out  1: one-cycle pulse when a start request is rejected.

## Operation
- **States.** IDLE, HDR, C, G, A, B. Counters: `row` (spans n or nc), `col` (spans ng) and `hdr` (0..2).
- **IDLE.** When `start_i` is high:
  - The block latches n, ng and nc.
  - If n > NMAX, ng > NGMAX or nc > NCMAX, it pulses `err_o` and stays in IDLE.
  - Otherwise it enters HDR.
- **HDR.** Sends 3 words, in order: n, ng, nc. Each is zero-extended to DATA_WIDTH.
- **C.** Sends `Z.c[row]` for row = 0..n-1.
- **G.** Sends `Z.G[row][col]`, row-major: col is the inner loop over 0..ng-1, row is the outer loop over 0..n-1.
- **A.** Sends `Z.A[row][col]`, row-major over nc x ng.
- **B.** Sends `Z.b[row]` for row = 0..nc-1.
- **Section skipping.** A section with zero words is skipped; the FSM moves straight to the next non-empty section.
  - n = 0 skips C and G.
  - ng = 0 skips G and A.
  - nc = 0 skips A and B.
  - HDR is never skipped.
- **Word count.** A transfer is exactly 3 + n + n·ng + nc·ng + nc words.
- **`last_o`.** Asserted on the final word of the transfer, whichever section that word is in. If n = nc = 0, that is the nc header word.
- **Counter advance.** Counters advance only on a handshake (`valid_o & ready_i`). The section changes on the handshake of a section's final word.
- **Start while busy.** `start_i` while `busy_o` is high is ignored; it causes no error pulse.
- **Dimension snapshot.** Only the latched dimensions are used during the transfer. Later changes to Z.n, Z.ng or Z.nc have no effect.

## Timing
- **Reset values.** `data_o` = 0, `valid_o` = 0, `sec_o` = 0, `last_o` = 0, `busy_o` = 0, `done_o` = 0, `err_o` = 0. State is IDLE and all counters are 0.
- **Registered outputs.** All outputs are registered.
- **Start latency.** `start_i` sampled high at edge t gives `valid_o` = 1, `data_o` = n, `sec_o` = 0 and `busy_o` = 1 after edge t. The first word can therefore be accepted at edge t+1.
- **Throughput.** With `ready_i` held high, the block moves one word per cycle with no bubbles, including across section boundaries.
- **Backpressure.** While `valid_o & ~ready_i`:
  - `data_o`, `sec_o` and `last_o` hold stable.
  - `valid_o` never drops until the handshake.
- **End of transfer.**
  - The handshake of the `last_o` word clears `valid_o` and `busy_o` on that same edge.
  - `done_o` is high for the following cycle only.
  - A new `start_i` is accepted in the cycle `done_o` is high, and the next transfer's first word follows one cycle later.
- **Error pulse.** `err_o` is high in the cycle after the rejected `start_i`. `valid_o` stays 0.
- **Mid-transfer reset.** Asserting `rstn_i` mid-transfer immediately returns every output to its reset value. No `done_o` is produced for the aborted transfer.

## Test plan
- **Full set, no backpressure.** n=2, ng=3, nc=1, c={1,2}, G=[[3,4,5],[6,7,8]], A=[[9,10,11]], b={12}, `ready_i`=1.
  - Expect 15 consecutive words: 2, 3, 1, 1..12.
  - `sec_o` sequence: 0,0,0,1,1,2×6,3×3,4.
  - `last_o` on word 15 only; `done_o` one cycle later.
- **Random backpressure.** Same set, `ready_i` toggled randomly.
  - Identical accepted sequence.
  - `data_o`, `sec_o` and `last_o` stable while stalled.
  - `valid_o` never deasserts before its handshake.
- **Empty sections.**
  - n=0, ng=2, nc=0: exactly 3 words (0, 2, 0), with `last_o` on the third.
  - n=2, ng=0, nc=1: 6 words (2, 0, 1, c0, c1, b0).
- **Oversize rejection.** Start with ng = NGMAX+1: `err_o` pulses for one cycle, `valid_o` and `busy_o` stay 0, and no words are emitted.
- **Start while busy and back-to-back.**
  - A `start_i` mid-transfer is ignored: word count is unchanged.
  - A `start_i` in the `done_o` cycle begins a new header one cycle later.
- **Reset mid-transfer.** Assert `rstn_i` during the G section: all outputs are 0 immediately. After release, a new start transmits the full sequence from the header.
